// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: HI/LO command encodings and FSM state type shared by the muldiv unit and the control block
package muldiv_unit_pkg;
    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;
endpackage

// File: rtl/muldiv_unit_div_core.sv
// div_core: 32-bit restoring divider on unsigned magnitudes, one quotient bit per cycle
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);
    logic [31:0] d;
    logic [5:0]  k;
    logic [32:0] t;
    // trial subtract of the divisor from the shifted partial remainder; t[32] is the borrow
    assign t    = {remainder, quotient[31]} - {1'b0, d};
    assign done = k == 6'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient  <= '0;
            remainder <= '0;
            d         <= '0;
            k         <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            d         <= divisor;
            k         <= 6'd32;
        end else if (!done) begin
            remainder <= t[32] ? {remainder[30:0], quotient[31]} : t[31:0];
            quotient  <= {quotient[30:0], ~t[32]};
            k         <= k - 6'd1;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the architectural HI and LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mult_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    md_state_t          state;
    logic [5:0]         cnt;
    logic signed [32:0] ma, mb;
    logic signed [65:0] prod;
    logic               q_neg, r_neg, b_zero, start, is_div;
    logic [31:0]        ua, ub, quo, rem;
    assign is_div = mult_op == MD_DIV;
    assign start  = state == S_IDLE && (is_div || mult_op == MD_DIVU);
    assign ua     = is_div && a[31] ? -a : a;
    assign ub     = is_div && b[31] ? -b : b;
    assign prod   = ma * mb;
    div_core u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (ua),
        .divisor   (ub),
        .quotient  (quo),
        .remainder (rem),
        .done      ()
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    case (mult_op)
                        MD_MTHI: hi <= a;
                        MD_MTLO: lo <= a;
                        MD_MULT, MD_MULTU: begin
                            ma    <= {mult_op == MD_MULT && a[31], a};
                            mb    <= {mult_op == MD_MULT && b[31], b};
                            cnt   <= 6'(MULT_LAT - 1);
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            q_neg  <= is_div && (a[31] ^ b[31]);
                            r_neg  <= is_div && a[31];
                            b_zero <= b == 32'd0;
                            cnt    <= 6'd32;
                            busy   <= 1'b1;
                            state  <= S_DIV;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    if (cnt == 6'd0) begin
                        {hi, lo} <= prod[63:0];
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else
                        cnt <= cnt - 6'd1;
                end
                S_DIV: begin
                    if (cnt == 6'd0) begin
                        if (!b_zero) begin
                            lo <= q_neg ? -quo : quo;
                            hi <= r_neg ? -rem : rem;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else
                        cnt <= cnt - 6'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  mult_op = MD_NONE;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi, lo;
    logic        busy;
    logic        inject = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          errors = 0, checks = 0;

    muldiv_unit #(.MULT_LAT(5)) dut (
        .clk(clk), .rst(rst), .mult_op(mult_op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    // any command presented while busy must be a deliberate injection
    always @(posedge clk)
        if (rst && busy && mult_op != MD_NONE)
            assert (inject) else begin
                errors++;
                $error("FAIL protocol observed=cmd_while_busy expected=none");
            end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, output int n);
        longint sx, sy, p;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        n  = 0;
        case (op)
            MD_MTHI: m_hi = x;
            MD_MTLO: m_lo = x;
            MD_MULT: begin p = sx * sy; {m_hi, m_lo} = p; n = 5; end
            MD_MULTU: begin up = ux * uy; {m_hi, m_lo} = up; n = 5; end
            MD_DIV: begin
                n = 33;
                if (y != 0) begin p = sx / sy; m_lo = p[31:0]; p = sx % sy; m_hi = p[31:0]; end
            end
            MD_DIVU: begin
                n = 33;
                if (y != 0) begin up = ux / uy; m_lo = up[31:0]; up = ux % uy; m_hi = up[31:0]; end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit intrude);
        logic [31:0] old_hi, old_lo;
        int n, cycles;
        old_hi = m_hi;
        old_lo = m_lo;
        model(op, x, y, n);
        @(negedge clk);
        mult_op = op; a = x; b = y;
        @(negedge clk);
        mult_op = MD_NONE;
        cycles = 0;
        while (busy && cycles < 100) begin
            chk("hold_hi", hi, old_hi);
            chk("hold_lo", lo, old_lo);
            cycles++;
            inject  = intrude && cycles == 1;
            mult_op = inject ? MD_MTLO : MD_NONE;
            a       = inject ? 32'h0000AAAA : x;
            @(negedge clk);
            mult_op = MD_NONE;
            inject  = 1'b0;
        end
        chk("latency", 32'(cycles), 32'(n));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    initial begin
        logic [2:0] op;
        logic [31:0] x, y;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_op(MD_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        chk("divu_hi", hi, 32'h00000001);
        run_op(MD_MTHI, 32'h1234, 32'd0, 1'b0);
        run_op(MD_MTLO, 32'h5678, 32'd0, 1'b0);
        run_op(MD_DIVU, 32'h9999, 32'd0, 1'b0);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);
        run_op(MD_MULT, 32'h00012345, 32'h00000100, 1'b1);
        chk("busy_mtlo_lo", lo, 32'h01234500);
        run_op(MD_NONE, 32'hDEAD, 32'hBEEF, 1'b0);
        run_op(3'b111, 32'hDEAD, 32'hBEEF, 1'b0);
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 6));
            x  = $urandom;
            y  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            run_op(op, x, y, 1'b0);
        end
        @(negedge clk);
        mult_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        mult_op = MD_NONE;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op(MD_MTHI, 32'd5, 32'd0, 1'b0);
        chk("post_rst_hi", hi, 32'd5);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
